// File: rtl/halloween_sequencer.sv
// halloween_sequencer: programmable show sequencer driving lamps, sounds and effects
// from a DEPTH-slot program of {opcode, hold duration} steps.
module halloween_sequencer #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [3+DUR_W:0]   wr_data,
    output logic [2:0]         color,
    output logic [2:0]         sound,
    output logic [2:0]         effect,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      pc
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    localparam logic [3:0] OP_RESET = 4'b0001;
    localparam logic [3:0] OP_HALT  = 4'b0011;

    state_t           state;
    logic [3+DUR_W:0] mem [DEPTH];
    logic [AW-1:0]    cur;
    logic [DUR_W-1:0] cnt;
    logic             fin;

    logic [3:0]       op;
    logic [DUR_W-1:0] dur;
    logic [2:0]       hot;
    logic             valid_lo, is_col, is_snd, is_eff, is_rst, last;
    logic [AW-1:0]    nxt;

    assign {op, dur} = mem[cur];
    assign hot       = 3'b001 << op[1:0];
    assign valid_lo  = op[1:0] != 2'b11;
    assign is_col    = op[3:2] == 2'b01 && valid_lo;
    assign is_snd    = op[3:2] == 2'b10 && valid_lo;
    assign is_eff    = op[3:2] == 2'b11 && valid_lo;
    assign is_rst    = op == OP_RESET;
    assign last      = cur == AW'(DEPTH - 1);
    assign nxt       = is_rst ? '0 : cur + 1'b1;

    // fin marks that the step just applied was the final one of a one-shot run;
    // the run ends at the edge where the following step would have been applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cur    <= '0;
            cnt    <= '0;
            fin    <= 1'b0;
            color  <= '0;
            sound  <= '0;
            effect <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pc     <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done <= 1'b0;
            if (wr_en) mem[wr_addr] <= wr_data;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                        cur   <= '0;
                        fin   <= 1'b0;
                    end
                end
                EXEC: begin
                    if (stop || fin) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= !stop;
                        sound  <= '0;
                        effect <= '0;
                    end else if (op == OP_HALT) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        sound  <= '0;
                        effect <= '0;
                        pc     <= cur;
                    end else begin
                        pc     <= cur;
                        color  <= is_rst ? 3'b000 : is_col ? hot : color;
                        sound  <= is_snd ? hot : 3'b000;
                        effect <= is_eff ? hot : 3'b000;
                        fin    <= !is_rst && last && !loop_en;
                        cur    <= nxt;
                        cnt    <= dur;
                        state  <= dur == '0 ? EXEC : HOLD;
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        sound  <= '0;
                        effect <= '0;
                    end else if (cnt == DUR_W'(1)) begin
                        state <= EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_halloween_sequencer.sv
// tb_halloween_sequencer: directed scenarios checked every cycle against a
// timeline model of the show, plus hand-computed literal expectations.
module tb_halloween_sequencer;
    localparam int DEPTH = 8;
    localparam int DUR_W = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst, start, stop, loop_en, wr_en;
    logic [AW-1:0] wr_addr;
    logic [3+DUR_W:0] wr_data;
    logic [2:0] color, sound, effect;
    logic busy, done;
    logic [AW-1:0] pc;

    always #5 clk = ~clk;

    halloween_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .color(color), .sound(sound), .effect(effect),
        .busy(busy), .done(done), .pc(pc)
    );

    int passed = 0, total = 0, ec = 0, ks = 0;
    bit chk_en = 1'b0;

    // Model: a run is a timeline of apply edges; each step's next apply edge is this edge + dur + 1.
    bit m_run = 0, m_fin = 0, m_done = 0;
    logic [2:0] m_color = 0, m_sound = 0, m_effect = 0;
    int m_pc = 0, m_slot = 0, m_next = 0, m_dur = 0;
    logic [3:0] m_op;
    logic [7:0] m_mem [DEPTH];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, ec, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        ec++;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_fin = 0; m_color = 0; m_sound = 0; m_effect = 0; m_pc = 0;
            foreach (m_mem[i]) m_mem[i] = 0;
        end else begin
            if (!m_run) begin
                if (start && !stop) begin m_run = 1; m_slot = 0; m_fin = 0; m_next = ec + 1; end
            end else if (stop) begin
                m_run = 0; m_sound = 0; m_effect = 0;
            end else if (ec == m_next) begin
                if (m_fin) begin
                    m_run = 0; m_done = 1; m_sound = 0; m_effect = 0;
                end else begin
                    m_op = m_mem[m_slot][7:4];
                    m_dur = int'(m_mem[m_slot][3:0]);
                    m_pc = m_slot;
                    m_sound = 0; m_effect = 0;
                    if (m_op == 4'b0011) begin
                        m_run = 0; m_done = 1;
                    end else begin
                        case (m_op)
                            4'b0001: m_color = 3'b000;
                            4'b0100: m_color = 3'b001;
                            4'b0101: m_color = 3'b010;
                            4'b0110: m_color = 3'b100;
                            4'b1000: m_sound = 3'b001;
                            4'b1001: m_sound = 3'b010;
                            4'b1010: m_sound = 3'b100;
                            4'b1100: m_effect = 3'b001;
                            4'b1101: m_effect = 3'b010;
                            4'b1110: m_effect = 3'b100;
                            default: ;
                        endcase
                        m_fin = m_op != 4'b0001 && m_slot == DEPTH - 1 && !loop_en;
                        m_slot = m_op == 4'b0001 ? 0 : (m_slot + 1) % DEPTH;
                        m_next = ec + m_dur + 1;
                    end
                end
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("color", color, m_color);
            chk("sound", sound, m_sound);
            chk("effect", effect, m_effect);
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("pc", pc, m_pc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic upto(input int t);
        while (ec < t) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [3:0] op, input logic [3:0] d);
        wr_en = 1; wr_addr = AW'(a); wr_data = {op, d};
        tick(1);
        wr_en = 0;
    endtask

    task automatic go();
        start = 1; ks = ec + 1;
        tick(1);
        start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; tick(1); stop = 0;
    endtask

    initial begin
        rst = 1; start = 1'($urandom); stop = 1'($urandom); loop_en = 1'($urandom);
        wr_en = 1'($urandom); wr_addr = AW'($urandom); wr_data = 8'($urandom);
        tick(2);
        chk("rst_color", color, 0); chk("rst_sound", sound, 0); chk("rst_effect", effect, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pc", pc, 0);
        rst = 0; start = 0; stop = 0; loop_en = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        chk_en = 1;
        tick(1);

        // Cleared memory reads back as eight NOPs.
        go();
        for (int i = 0; i < 40 && !done; i++) tick(1);
        chk("nop_done_edge", ec, ks + 1 + DEPTH);
        tick(2);

        // Basic run.
        wr(0, 4'b0100, 4'd2); wr(1, 4'b1010, 4'd0); wr(2, 4'b0011, 4'd0);
        go();
        upto(ks + 1); chk("basic_color", color, 3'b001); chk("basic_sound0", sound, 0);
        upto(ks + 4); chk("basic_boo", sound, 3'b100);
        upto(ks + 5); chk("basic_busy", busy, 0); chk("basic_done", done, 1);
        chk("basic_sound_clr", sound, 0); chk("basic_color_keep", color, 3'b001);
        upto(ks + 6); chk("basic_done_drop", done, 0);

        // Looping with fog on slot 7, then one-shot completion.
        for (int i = 0; i < 7; i++) wr(i, 4'b0000, 4'd0);
        wr(7, 4'b1110, 4'd0);
        loop_en = 1;
        go();
        upto(ks + 8); chk("loop_fog1", effect, 3'b100); chk("loop_pc7", pc, 7);
        upto(ks + 9); chk("loop_wrap_pc", pc, 0); chk("loop_fog_off", effect, 0);
        upto(ks + 16); chk("loop_fog2", effect, 3'b100);
        upto(ks + 17); loop_en = 0;
        upto(ks + 24); chk("loop_last_busy", busy, 1);
        upto(ks + 25); chk("loop_end_done", done, 1); chk("loop_end_busy", busy, 0);
        tick(2);

        // Stop during a hold.
        wr(0, 4'b1100, 4'd5); wr(1, 4'b0011, 4'd0);
        go();
        upto(ks + 1); chk("stop_wave", effect, 3'b001);
        upto(ks + 2); pulse_stop();
        chk("stop_busy", busy, 0); chk("stop_effect", effect, 0);
        chk("stop_color", color, 3'b001); chk("stop_done", done, 0);

        // start with stop in IDLE stays idle; start while busy is ignored.
        start = 1; stop = 1; tick(1); start = 0; stop = 0;
        chk("startstop_idle", busy, 0);
        go();
        upto(ks + 2); start = 1; tick(1); start = 0;
        upto(ks + 6); chk("restart_pc", pc, 0);
        upto(ks + 7); chk("restart_halt_pc", pc, 1); chk("restart_done", done, 1);
        tick(2);

        // RESET opcode restarts the program and clears colour.
        wr(0, 4'b0000, 4'd0); wr(1, 4'b0110, 4'd0); wr(2, 4'b0001, 4'd0);
        go();
        upto(ks + 2); chk("rop_orange", color, 3'b100);
        upto(ks + 3); chk("rop_clear", color, 0); chk("rop_pc2", pc, 2);
        upto(ks + 4); chk("rop_pc0", pc, 0);
        upto(ks + 9); chk("rop_again", color, 0); chk("rop_busy", busy, 1);
        pulse_stop();
        chk("rop_stopped", busy, 0);

        // Rewrite slot 3 at the edge it is applied.
        for (int i = 0; i < 8; i++) wr(i, 4'b0000, 4'd0);
        wr(3, 4'b1000, 4'd2);
        loop_en = 1;
        go();
        upto(ks + 3); wr(3, 4'b1001, 4'd0);
        chk("rewrite_old", sound, 3'b001);
        upto(ks + 14); chk("rewrite_new", sound, 3'b010); chk("rewrite_pc", pc, 3);
        pulse_stop();

        // rst during a hold.
        wr(0, 4'b0101, 4'd5);
        go();
        upto(ks + 1); chk("hold_purple", color, 3'b010);
        upto(ks + 2); rst = 1; tick(1);
        chk("mid_rst_color", color, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_pc", pc, 0);
        rst = 0;
        tick(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/halloween_sequencer.md
# halloween_sequencer

Programmable show sequencer for the Halloween decoration: holds a DEPTH-slot program of 4-bit decoration opcodes, each with a hold duration. It steps through the program on `clk` and drives persistent colour lamps, per-step sound and effect outputs. It supersedes the fixed 4-slot, 2-bit-counter breadboard datapath, adding loadable depth, per-step timing, loop/one-shot mode, halt, jump-to-start and stop.

## Interface
- `DEPTH`, default 8: program slots; power of two, at least 2. `AW = clog2(DEPTH)`.
- `DUR_W`, default 4: width of the per-step duration field.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high; one clock `clk`.
- `start`  in  1  begin program at slot 0; ignored while `busy`.
- `stop`  in  1  abort run; wins over `start` in the same cycle.
- `loop_en`  in  1  1: wrap from last slot to slot 0; 0: one-shot.
- `wr_en`  in  1  program write strobe.
- `wr_addr`  in  AW  slot written.
- `wr_data`  in  4+DUR_W  `{opcode[3:0], dur[DUR_W-1:0]}`.
- `color`  out  3  one-hot lamp: bit0 green, bit1 purple, bit2 orange; level, persists across steps.
- `sound`  out  3  bit0 scream, bit1 cackle, bit2 boo; asserted for its step only.
- `effect`  out  3  bit0 wave hands, bit1 move jaw, bit2 fog; asserted for its step only.
- `busy`  out  1  program running.
- `done`  out  1  one-cycle pulse on normal completion (end of one-shot or HALT).
- `pc`  out  AW  slot index of the step currently applied.

## Operation
- Opcode map:
  - 0000: ON/NOP.
  - 0001: RESET. Clears `color`, `sound` and `effect`; the next step is slot 0.
  - 0011: HALT.
  - 0100/0101/0110: set `color` to green/purple/orange.
  - 1000/1001/1010: scream/cackle/boo.
  - 1100/1101/1110: wave/jaw/fog.
  - All other codes (0010, 0111, 1011, 1111): NOP.
- Sound and effect opcodes update `sound`/`effect` with a one-hot value and zero the other group. Colour and NOP opcodes zero both groups; `color` is unchanged except by colour opcodes and RESET.
- Program memory: DEPTH x (4+DUR_W) registers, written on any cycle with `wr_en`.
  - A write lands at the edge. A write to the slot being executed affects only later executions of that slot.
- States:
  - IDLE: `busy`=0. `start` & !`stop` -> EXEC with pc=0.
  - EXEC: one cycle. At its closing edge, apply mem[pc] to the outputs and latch `dur`.
    - HALT -> IDLE: clear `sound`/`effect`, pulse `done`.
    - Otherwise, if `dur`=0 -> EXEC for the next slot; else -> HOLD with count=`dur`.
  - HOLD: decrement count. When count reaches 1 -> EXEC for the next slot.
- Next slot:
  - After RESET: slot 0.
  - Otherwise pc+1.
  - Last slot (pc=DEPTH-1), with `loop_en` sampled at that slot's EXEC edge:
    - `loop_en`=1: wrap to 0.
    - `loop_en`=0: when the last step's duration expires, go to IDLE, clear `sound`/`effect` and pulse `done`.
- `stop` in EXEC or HOLD: next edge -> IDLE, clear `sound`/`effect`, keep `color`, no `done`. `stop` in IDLE: no effect.

## Timing
- Reset, and every output after `rst`: `color`=0, `sound`=0, `effect`=0, `busy`=0, `done`=0, `pc`=0, state IDLE, memory cleared to all-zero (NOP, dur 0).
- `rst` mid-run: same values at the next edge; `rst` overrides all other inputs.
- Edge numbering: `start` sampled at edge k -> `busy`=1 after k. Slot 0 is applied at edge k+1.
- Step length: each step's outputs hold for exactly dur+1 cycles. The next step is applied at edge k+1+(dur0+1), and so on.
- `pc` updates at the same edge as the outputs it names.
- HALT: `busy` drops and `done`=1 at HALT's apply edge; `done` returns to 0 one edge later.
- One-shot end: `busy` drops and `done` pulses at edge (apply_last + dur_last + 1).
- `start` while `busy`: ignored, no restart.
- Duration arithmetic: unsigned, no overflow. A dur of all-ones gives 2^DUR_W cycles.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs -> all outputs 0; reading every slot back via a run gives NOPs, `done` at edge k+1+DEPTH.
- Basic run (DEPTH=8), program {0100,2}, {1010,0}, {0011,x}; `start` sampled at edge 1:
  - `color`=001 from edge 2, `sound`=0.
  - `sound`=100 at edge 5 for 1 cycle.
  - Edge 6: `busy`=0, `sound`=0, `done`=1 for one cycle, `color` stays 001.
- Loop: 8 slots, slot 7 = {1110,0}, others NOP dur 0, `loop_en`=1:
  - `effect`=100 every 8 cycles, `pc` wraps 7->0, no `done`.
  - Drop `loop_en` -> completion after the next slot 7, `done` once.
- Stop/priority:
  - `stop` during a HOLD of {1100,5} -> IDLE next edge, `effect`=0, `color` kept, `done`=0.
  - `start` and `stop` together in IDLE -> remains IDLE.
  - `start` while busy -> `pc` sequence undisturbed.
- RESET opcode: slot 2 = {0001,0} after orange in slot 1 -> `color`=000 and `pc`=0 on the following step; the run repeats until `stop`.
- Mid-run rewrite and `rst`:
  - Write slot 3 while executing slot 3 -> the old opcode is applied this pass, the new one on the next loop.
  - `rst` during HOLD -> all outputs 0 at the next edge.
